register_file_sb: RTL and testbench
===================================

# register_file_sb

Parametrised successor to the integer register file. It provides two combinational read ports, one synchronous write port and a read-only debug port. It adds three things: configurable width and register count, a per-register pending-write scoreboard for multi-cycle producers (loads), and optional write-to-read bypass. It sits between decode (reads, stall detection) and writeback (writes) in the RISC-V core datapath.

## Interface
- WIDTH, 32, data width of each register
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- we  input  1  write enable
- Rd  input  ADDR_W  write address
- WD  input  WIDTH  write data
- Rs1, Rs2  input  ADDR_W  read addresses
- RD1, RD2  output  WIDTH  read data
- Debug_Source  input  ADDR_W  debug read address
- Debug_Output  output  WIDTH  debug read data (stored value only)
- pend_set  input  1  mark register pend_addr as awaiting a write
- pend_addr  input  ADDR_W  register to mark pending
- Busy1, Busy2  output  1  Rs1 / Rs2 has an outstanding pending write
- Pend_Count  output  ADDR_W+1  number of registers currently pending

## Operation
- Register 0 is hardwired to zero: writes to it are ignored, pend_set for it is ignored, and it always reads 0 and never reports busy.
- Storage: DEPTH-1 registers of WIDTH bits (indices 1..DEPTH-1), plus a pending bit per register.
- Write: at a rising edge with we=1 and Rd≠0, reg[Rd] ← WD and pending[Rd] ← 0.
- Pend set: at a rising edge with pend_set=1 and pend_addr≠0, pending[pend_addr] ← 1.
- Same-edge set and clear on the same register: set wins. The write data is still stored, and the pending bit ends at 1, because the newer producer owns the register.
- Reads: RDn = 0 if Rsn=0; otherwise reg[Rsn], subject to the bypass described under Configuration.
- Busy: Busyn = pending[Rsn] and Rsn≠0, subject to the bypass described under Configuration.
- Debug_Output = 0 if Debug_Source=0; otherwise reg[Debug_Source]. It is never bypassed and never affected by pending state.
- Pend_Count equals the population count of the pending bits. It is registered and updated in the same edge as the bits themselves.
- Reset: every register ← 0, every pending bit ← 0, Pend_Count ← 0. Reset overrides a we or pend_set sampled in the same cycle.
- Consequence of reset: the cycle after reset, RD1, RD2 and Debug_Output read 0 and Busy1, Busy2 read 0 for every address.

## Timing
- Read ports, Busy outputs and Debug_Output are combinational from addresses and state, with zero-cycle latency.
- Writes and pending updates are visible one edge later. Without bypass, a value written at edge N is readable after edge N.
- Pend_Count changes only on clock edges: +1 on a set of a non-pending register, −1 on a clear of a pending register, 0 when both apply to the same register.
  - A set on one register and a clear on a different one in the same cycle nets 0.
- Maximum Pend_Count is DEPTH−1. It cannot overflow because a set of an already-pending register does not increment.
- Reset asserted mid-operation takes effect on the next edge. It discards outstanding pending marks without any write.

## Configuration
- Macro: RF_BYPASS_EN.
- Defined: if we=1, Rd≠0 and Rsn=Rd, then RDn = WD and Busyn = 0 in the same cycle. A consumer waiting on a load is released in the writeback cycle.
- Not defined: reads return stored values only. Busyn stays 1 through the writeback cycle and drops one cycle later.
- In both cases Debug_Output and Pend_Count behave identically.

## Test plan
- Reset with registers preloaded to nonzero values → after one edge, RD1, RD2 and Debug_Output read 0 for all addresses, Busy1, Busy2 read 0, Pend_Count=0.
- Write 0xDEADBEEF to r0, then read Rs1=0 → RD1=0. Write 0x12345678 to r7, read Rs2=7 next cycle → RD2=0x12345678, and Debug_Source=7 gives the same.
- pend_set r5, r6 on consecutive edges → Pend_Count 1 then 2, Busy1=1 with Rs1=5. Write r5=0xA5 → Pend_Count=1, Busy1=0 after the edge.
- Same edge: we to r9 with WD=0x55 and pend_set r9 → reg[9]=0x55, pending[9]=1, Pend_Count +1.
- Bypass: Rs1=Rd=3, we=1, WD=0xCAFE, pending[3]=1 → with RF_BYPASS_EN, RD1=0xCAFE and Busy1=0 in that cycle. Without it, RD1 = the old value and Busy1=1, then 0xCAFE and 0 the next cycle.
- Reset asserted in the same cycle as we to r4 and pend_set r8 → both ignored, reg[4]=0, Pend_Count=0.

Source files
------------

// File: rtl/register_file_sb_if.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_sb_if
//  Brief    : Read/write/debug/scoreboard bus of the register file.
//  Revision : 1.0 - initial release
// ============================================================================
interface register_file_sb_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
);
   logic                we;
   logic [ADDR_W-1:0]   Rd;
   logic [WIDTH-1:0]    WD;
   logic [ADDR_W-1:0]   Rs1;
   logic [ADDR_W-1:0]   Rs2;
   logic [WIDTH-1:0]    RD1;
   logic [WIDTH-1:0]    RD2;
   logic [ADDR_W-1:0]   Debug_Source;
   logic [WIDTH-1:0]    Debug_Output;
   logic                pend_set;
   logic [ADDR_W-1:0]   pend_addr;
   logic                Busy1;
   logic                Busy2;
   logic [ADDR_W:0]     Pend_Count;

   modport master (
      output we, Rd, WD, Rs1, Rs2, Debug_Source, pend_set, pend_addr,
      input  RD1, RD2, Debug_Output, Busy1, Busy2, Pend_Count
   );

   modport slave (
      input  we, Rd, WD, Rs1, Rs2, Debug_Source, pend_set, pend_addr,
      output RD1, RD2, Debug_Output, Busy1, Busy2, Pend_Count
   );
endinterface
`default_nettype wire

// File: rtl/register_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_sb
//  Brief    : 2R/1W register file with pending-write scoreboard and debug port.
//             Optional write-to-read bypass enabled by macro RF_BYPASS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module register_file_sb #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   register_file_sb_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0] r_regs [1:DEPTH-1];
   logic [DEPTH-1:0] r_pend;
   logic [ADDR_W:0]  r_pend_count;

   logic [DEPTH-1:0] w_pend_next;
   logic [ADDR_W:0]  w_pend_count_next;
   logic             w_wr_en;
   logic             w_set_en;
   logic             w_byp1;
   logic             w_byp2;

   assign w_wr_en  = bus.we && (bus.Rd != '0);
   assign w_set_en = bus.pend_set && (bus.pend_addr != '0);

   // Clear first, then set: a new producer claiming the register wins over
   // the writeback of the previous one on the same edge.
   always_comb begin
      w_pend_next       = r_pend;
      w_pend_count_next = '0;
      if (w_wr_en) begin
         w_pend_next[bus.Rd] = 1'b0;
      end
      if (w_set_en) begin
         w_pend_next[bus.pend_addr] = 1'b1;
      end
      w_pend_next[0] = 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
         w_pend_count_next = w_pend_count_next + (ADDR_W+1)'(w_pend_next[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 1; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[bus.Rd] <= bus.WD;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend       <= '0;
         r_pend_count <= '0;
      end else begin
         r_pend       <= w_pend_next;
         r_pend_count <= w_pend_count_next;
      end
   end

`ifdef RF_BYPASS_EN
   assign w_byp1 = w_wr_en && (bus.Rs1 == bus.Rd);
   assign w_byp2 = w_wr_en && (bus.Rs2 == bus.Rd);
`else
   assign w_byp1 = 1'b0;
   assign w_byp2 = 1'b0;
`endif

   assign bus.RD1 = (bus.Rs1 == '0) ? '0 : (w_byp1 ? bus.WD : r_regs[bus.Rs1]);
   assign bus.RD2 = (bus.Rs2 == '0) ? '0 : (w_byp2 ? bus.WD : r_regs[bus.Rs2]);

   assign bus.Busy1 = (bus.Rs1 != '0) && r_pend[bus.Rs1] && !w_byp1;
   assign bus.Busy2 = (bus.Rs2 != '0) && r_pend[bus.Rs2] && !w_byp2;

   assign bus.Debug_Output = (bus.Debug_Source == '0) ? '0 : r_regs[bus.Debug_Source];
   assign bus.Pend_Count   = r_pend_count;

endmodule
`default_nettype wire

// File: tb/tb_register_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file_sb
//  Brief    : Scoreboard bench for register_file_sb against an array model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_sb;
   localparam int WIDTH  = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   register_file_sb_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   register_file_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [WIDTH-1:0] rd1;
      logic [WIDTH-1:0] rd2;
      logic [WIDTH-1:0] dbg;
      logic             b1;
      logic             b2;
      logic [ADDR_W:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   logic [WIDTH-1:0] m_reg  [DEPTH];
   bit               m_pend [DEPTH];
   bit               m_known = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Expected view of one read port in the current cycle.
   function automatic void model_read(input logic [ADDR_W-1:0] rs, input logic we_v,
                                      input logic [ADDR_W-1:0] rd_v, input logic [WIDTH-1:0] wd_v,
                                      output logic [WIDTH-1:0] data, output logic busy);
      bit fwd;
`ifdef RF_BYPASS_EN
      fwd = we_v && (rd_v != 0) && (rs == rd_v);
`else
      fwd = 1'b0;
`endif
      if (rs == 0) begin
         data = '0;
         busy = 1'b0;
      end else begin
         data = fwd ? wd_v : m_reg[rs];
         busy = m_pend[rs] && !fwd;
      end
   endfunction

   task automatic apply(input logic rst_v, input logic we_v, input logic [ADDR_W-1:0] rd_v,
                        input logic [WIDTH-1:0] wd_v, input logic [ADDR_W-1:0] rs1_v,
                        input logic [ADDR_W-1:0] rs2_v, input logic [ADDR_W-1:0] dbg_v,
                        input logic ps_v, input logic [ADDR_W-1:0] pa_v);
      exp_t e;
      int   n;
      @(negedge clk);
      reset            = rst_v;
      bus.we           = we_v;
      bus.Rd           = rd_v;
      bus.WD           = wd_v;
      bus.Rs1          = rs1_v;
      bus.Rs2          = rs2_v;
      bus.Debug_Source = dbg_v;
      bus.pend_set     = ps_v;
      bus.pend_addr    = pa_v;
      if (m_known) begin
         model_read(rs1_v, we_v, rd_v, wd_v, e.rd1, e.b1);
         model_read(rs2_v, we_v, rd_v, wd_v, e.rd2, e.b2);
         e.dbg = (dbg_v == 0) ? '0 : m_reg[dbg_v];
         n = 0;
         for (int i = 0; i < DEPTH; i++) n += int'(m_pend[i]);
         e.cnt = (ADDR_W+1)'(n);
         exp_q.push_back(e);
      end
      // State after the coming edge.
      if (rst_v) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
         end
         m_known = 1'b1;
      end else if (m_known) begin
         if (we_v && rd_v != 0) begin
            m_reg[rd_v]  = wd_v;
            m_pend[rd_v] = 1'b0;
         end
         if (ps_v && pa_v != 0) m_pend[pa_v] = 1'b1;
      end
   endtask

   task automatic idle(input logic [ADDR_W-1:0] rs1_v, input logic [ADDR_W-1:0] rs2_v,
                       input logic [ADDR_W-1:0] dbg_v);
      apply(1'b0, 1'b0, '0, '0, rs1_v, rs2_v, dbg_v, 1'b0, '0);
   endtask

   always @(negedge clk) begin
      #2;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         vectors++;
         chk("RD1",          bus.RD1,          mon_e.rd1);
         chk("RD2",          bus.RD2,          mon_e.rd2);
         chk("Debug_Output", bus.Debug_Output, mon_e.dbg);
         chk("Busy1",        WIDTH'(bus.Busy1),      WIDTH'(mon_e.b1));
         chk("Busy2",        WIDTH'(bus.Busy2),      WIDTH'(mon_e.b2));
         chk("Pend_Count",   WIDTH'(bus.Pend_Count), WIDTH'(mon_e.cnt));
      end
   end

   function automatic logic [ADDR_W-1:0] rnd_addr();
      if ($urandom_range(0, 1) == 0) return ADDR_W'($urandom_range(0, 7));
      return ADDR_W'($urandom_range(0, DEPTH-1));
   endfunction

   initial begin
      logic [ADDR_W-1:0] a;
      reset = 1'b1;
      bus.we = 1'b0; bus.Rd = '0; bus.WD = '0; bus.Rs1 = '0; bus.Rs2 = '0;
      bus.Debug_Source = '0; bus.pend_set = 1'b0; bus.pend_addr = '0;

      apply(1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b0, '0);
      // Preload every register and mark several pending.
      for (int i = 1; i < DEPTH; i++) begin
         a = ADDR_W'(i);
         apply(1'b0, 1'b1, a, $urandom() | 32'h1, a, a, a, (i % 3) == 0, ADDR_W'(DEPTH - i));
      end
      idle(5'd3, 5'd4, 5'd8);
      // Reset wins over same-cycle write and pend_set.
      apply(1'b1, 1'b1, 5'd4, 32'h4444_4444, 5'd4, 5'd8, 5'd4, 1'b1, 5'd8);
      for (int i = 0; i < DEPTH; i++) begin
         a = ADDR_W'(i);
         idle(a, ADDR_W'(DEPTH - 1 - i), a);
      end

      // r0 is hardwired.
      apply(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0);
      idle(5'd0, 5'd0, 5'd0);
      apply(1'b0, 1'b1, 5'd7, 32'h1234_5678, 5'd1, 5'd7, 5'd7, 1'b0, 5'd0);
      idle(5'd7, 5'd7, 5'd7);

      // Scoreboard set/clear.
      apply(1'b0, 1'b0, '0, '0, 5'd5, 5'd6, 5'd0, 1'b1, 5'd5);
      apply(1'b0, 1'b0, '0, '0, 5'd5, 5'd6, 5'd0, 1'b1, 5'd6);
      idle(5'd5, 5'd6, 5'd5);
      apply(1'b0, 1'b1, 5'd5, 32'h0000_00A5, 5'd5, 5'd6, 5'd5, 1'b0, 5'd0);
      idle(5'd5, 5'd6, 5'd5);

      // Same-edge write and set on one register.
      apply(1'b0, 1'b1, 5'd9, 32'h0000_0055, 5'd9, 5'd6, 5'd9, 1'b1, 5'd9);
      idle(5'd9, 5'd6, 5'd9);
      // Set on one register with clear of another nets zero.
      apply(1'b0, 1'b1, 5'd6, 32'h0000_0066, 5'd6, 5'd9, 5'd6, 1'b1, 5'd10);
      idle(5'd6, 5'd10, 5'd6);

      // Writeback of a pending load with the consumer reading it.
      apply(1'b0, 1'b1, 5'd3, 32'h0000_1111, 5'd3, 5'd3, 5'd3, 1'b1, 5'd3);
      apply(1'b0, 1'b1, 5'd3, 32'h0000_CAFE, 5'd3, 5'd3, 5'd3, 1'b0, 5'd0);
      idle(5'd3, 5'd3, 5'd3);

      // Reset mid-operation with pending marks outstanding.
      apply(1'b1, 1'b1, 5'd4, 32'h0000_4444, 5'd9, 5'd10, 5'd4, 1'b1, 5'd8);
      idle(5'd4, 5'd8, 5'd4);

      // Randomised traffic.
      for (int k = 0; k < 3000; k++) begin
         apply(($urandom_range(0, 127) == 0), ($urandom_range(0, 1) == 1), rnd_addr(), $urandom(),
               rnd_addr(), rnd_addr(), rnd_addr(), ($urandom_range(0, 2) == 0), rnd_addr());
      end

      repeat (2) @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain actual=%0d required=0 entries left", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
